// File: rtl/bf_mem_arbiter.sv
// bf_mem_arbiter: shares one single-port memory between fetch and data ports; data first, fetch anti-starvation.
// Optional BF_ARB_TIMEOUT_EN: forced completion after TIMEOUT_CYCLES memory wait cycles, sticky err_o.
module bf_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                if_valid_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_ready_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                d_valid_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_wstrb_i,
    output logic                d_ready_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_valid_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_ready_i,
    output logic                err_o
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_IF} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] starve_cnt, starve_nxt;
    logic          grant_d, grant_if, done, timeout;

    if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("bf_mem_arbiter: STARVE_LIMIT and TIMEOUT_CYCLES must be >= 1");
    end

`ifdef BF_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;
    logic          err;

    // fires on the TIMEOUT_CYCLES-th consecutive busy cycle without mem_ready_i
    assign timeout = state != IDLE && !mem_ready_i && wait_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign err_o   = err;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            wait_cnt <= (state == IDLE || done) ? '0 : wait_cnt + 1'b1;
            err      <= err || timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    assign done = state != IDLE && (mem_ready_i || timeout);

    always_comb begin
        grant_d    = state == IDLE && d_valid_i && !(if_valid_i && starve_cnt == CW'(STARVE_LIMIT));
        grant_if   = state == IDLE && !grant_d && if_valid_i;
        state_nxt  = grant_d ? BUSY_D : grant_if ? BUSY_IF : done ? IDLE : state;
        starve_nxt = state != IDLE ? starve_cnt :
                     (grant_if || !if_valid_i) ? '0 :
                     (grant_d && starve_cnt != CW'(STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_valid_o <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
        end else if (grant_d) begin
            mem_valid_o <= 1'b1;
            mem_we_o    <= d_we_i;
            mem_addr_o  <= d_addr_i;
            mem_wdata_o <= d_wdata_i;
            mem_wstrb_o <= d_wstrb_i;
        end else if (grant_if) begin
            mem_valid_o <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
        end else if (done) begin
            mem_valid_o <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
        end
    end

    assign if_ready_o = state == BUSY_IF && done;
    assign d_ready_o  = state == BUSY_D && done;
    assign if_rdata_o = if_ready_o ? (timeout ? DATA_W'(32'hDEAD_BEEF) : mem_rdata_i) : '0;
    assign d_rdata_o  = d_ready_o ? (timeout ? DATA_W'(32'hDEAD_BEEF) : mem_rdata_i) : '0;
endmodule
